// File: rtl/msi_bus_memory_responder_if.sv
// Snoop-bus view of the memory responder: command inputs from the bus mux,
// registered read responses back to the cache controllers.
interface msi_bus_memory_responder_if #(
  parameter int ADDR_BITS = 11,
  parameter int DATA_BITS = 16
) ();
  logic [1:0]           bus_cmd_in;
  logic [ADDR_BITS-1:0] bus_addr_in;
  logic [DATA_BITS-1:0] bus_data_in;
  logic                 resp_valid;
  logic [ADDR_BITS-1:0] resp_addr;
  logic [DATA_BITS-1:0] resp_data;
  logic                 resp_excl;
  logic                 busy;

  modport master (
    output bus_cmd_in, bus_addr_in, bus_data_in,
    input  resp_valid, resp_addr, resp_data,
    input  resp_excl, busy
  );

  modport slave (
    input  bus_cmd_in, bus_addr_in, bus_data_in,
    output resp_valid, resp_addr, resp_data,
    output resp_excl, busy
  );
endinterface

// File: rtl/msi_bus_memory_responder.sv
// Main-memory responder on the MSI snoop bus: fixed-latency reads, Flush writes.
// MEM_FLUSH_FORWARD_EN: a Flush hitting the pending read completes it early.
module msi_bus_memory_responder #(
  parameter int ADDR_BITS   = 11,
  parameter int DATA_BITS   = 16,
  parameter int MEM_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  msi_bus_memory_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] lat_addr_q;
  logic                 lat_excl_q;
  logic                 is_rd, is_fl, hit;
  logic                 load, done;

  logic                 valid_q, busy_q, excl_q;
  logic [ADDR_BITS-1:0] raddr_q;
  logic [DATA_BITS-1:0] rdata_q;

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_comb begin
    is_rd = (bus.bus_cmd_in == 2'b01) ||
            (bus.bus_cmd_in == 2'b10);
    is_fl = (bus.bus_cmd_in == 2'b11);
    hit   = is_fl && (bus.bus_addr_in == lat_addr_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_rd) begin
          load    = 1'b1;
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
`ifdef MEM_FLUSH_FORWARD_EN
        if (hit || cnt_q == 4'd0) begin
`else
        if (cnt_q == 4'd0) begin
`endif
          done    = 1'b1;
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Array contents survive reset; only Flush ever writes them.
  always_ff @(posedge clk) begin
    if (is_fl)
      mem[bus.bus_addr_in] <= bus.bus_data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      lat_addr_q <= '0;
      lat_excl_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      raddr_q    <= '0;
      rdata_q    <= '0;
      excl_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == RESP);
      busy_q  <= (state_d != IDLE);
      if (load) begin
        lat_addr_q <= bus.bus_addr_in;
        lat_excl_q <= (bus.bus_cmd_in == 2'b10);
      end
      // Same-edge Flush to the read address wins over the stale array word.
      if (done) begin
        raddr_q <= lat_addr_q;
        excl_q  <= lat_excl_q;
        rdata_q <= hit ? bus.bus_data_in : mem[lat_addr_q];
      end
    end
  end

  assign bus.resp_valid = valid_q;
  assign bus.resp_addr  = raddr_q;
  assign bus.resp_data  = rdata_q;
  assign bus.resp_excl  = excl_q;
  assign bus.busy       = busy_q;

endmodule
